// File: rtl/perceptron_train_engine_pkg.sv
// Shared geometry helpers, saturating weight arithmetic and FSM state type
// for the perceptron training engine.
package perceptron_train_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    function automatic int nchunk_of(input int nw, input int lanes);
        return (nw + lanes - 1) / lanes;
    endfunction

    // A single-chunk row still gets a 1-bit chunk field so widths stay legal.
    function automatic int cw_of(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

    function automatic int wmax_of(input int ww);
        return (1 << (ww - 1)) - 1;
    endfunction

    function automatic int wmin_of(input int ww);
        return -(1 << (ww - 1));
    endfunction

    localparam int WMAX = wmax_of(3);
    localparam int WMIN = wmin_of(3);

    function automatic int sat_inc(input int w, input int ww);
        return (w >= wmax_of(ww)) ? w : w + 1;
    endfunction

    function automatic int sat_dec(input int w, input int ww);
        return (w <= wmin_of(ww)) ? w : w - 1;
    endfunction

endpackage

// File: rtl/perceptron_train_engine_if.sv
// Request, weight-RAM and completion signals of the training engine.
// Handshake: a request transfers on a clock edge where req_valid & req_ready are both 1;
// the source holds all req_* fields stable while req_valid=1 and req_ready=0.
interface perceptron_train_engine_if
    import perceptron_train_engine_pkg::*;
#(
    parameter int HIST_LEN = 16,
    parameter int WEIGHT_W = 3,
    parameter int LANES    = 4,
    parameter int INDEX_W  = 6,
    parameter int SUM_W    = 9,
    parameter int AW       = INDEX_W + cw_of(nchunk_of(HIST_LEN + 1, LANES))
);
    logic                      req_valid;
    logic                      req_ready;
    logic [INDEX_W-1:0]        req_index;
    logic [HIST_LEN-1:0]       req_hist;
    logic                      req_dir;
    logic                      req_pred;
    logic [SUM_W-1:0]          req_sum;
    logic                      wt_rd_en;
    logic [AW-1:0]             wt_rd_addr;
    logic [LANES*WEIGHT_W-1:0] wt_rd_data;
    logic                      wt_wr_en;
    logic [AW-1:0]             wt_wr_addr;
    logic [LANES*WEIGHT_W-1:0] wt_wr_data;
    logic                      done;
    logic                      trained;
    logic [15:0]               train_cnt;

    modport master (
        output req_valid, req_index, req_hist, req_dir, req_pred, req_sum, wt_rd_data,
        input  req_ready, wt_rd_en, wt_rd_addr, wt_wr_en, wt_wr_addr, wt_wr_data,
               done, trained, train_cnt
    );

    modport slave (
        input  req_valid, req_index, req_hist, req_dir, req_pred, req_sum, wt_rd_data,
        output req_ready, wt_rd_en, wt_rd_addr, wt_wr_en, wt_wr_addr, wt_wr_data,
               done, trained, train_cnt
    );
endinterface

// File: rtl/perceptron_train_engine_weight_vec_update.sv
// Combinational LANES-wide saturating weight update; masked-off lanes pass through.
module perceptron_train_engine_weight_vec_update
    import perceptron_train_engine_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int WEIGHT_W = 3
) (
    input  logic [LANES*WEIGHT_W-1:0] data,
    input  logic [LANES-1:0]          hist,
    input  logic [LANES-1:0]          lane_valid,
    input  logic                      dir,
    output logic [LANES*WEIGHT_W-1:0] result
);
    always_comb begin
        result = data;
        for (int l = 0; l < LANES; l++) begin
            int w;
            w = int'($signed(data[l*WEIGHT_W +: WEIGHT_W]));
            if (lane_valid[l]) begin
                w = (dir == hist[l]) ? sat_inc(w, WEIGHT_W) : sat_dec(w, WEIGHT_W);
                result[l*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(w);
            end
        end
    end
endmodule

// File: rtl/perceptron_train_engine.sv
// Perceptron training engine: decides whether to train on each resolved branch and
// walks the row through the weight RAM one chunk at a time (read, then write back).
module perceptron_train_engine
    import perceptron_train_engine_pkg::*;
#(
    parameter int HIST_LEN = 16,
    parameter int WEIGHT_W = 3,
    parameter int LANES    = 4,
    parameter int INDEX_W  = 6,
    parameter int SUM_W    = 9,
    parameter int THETA    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    perceptron_train_engine_if.slave    bus,
    output state_t                      dbg_state
);
    localparam int NW     = HIST_LEN + 1;
    localparam int NCHUNK = nchunk_of(NW, LANES);
    localparam int CW     = cw_of(NCHUNK);
    localparam int AW     = INDEX_W + CW;
    localparam int PADW   = NCHUNK * LANES;

    state_t                    state, state_nxt;
    logic [CW-1:0]             chunk;
    logic [AW-1:0]             addr;
    logic [PADW-1:0]           hist_pad;
    logic                      dir_q;
    logic                      nt_q;
    logic [15:0]               cnt;
    logic                      accept, train, last_chunk;
    logic [SUM_W:0]            sum_ext, sum_abs;
    logic [LANES-1:0]          lane_hist, lane_valid;
    logic [LANES*WEIGHT_W-1:0] upd;

    // Widen before negating so the most negative sum has a representable magnitude.
    assign sum_ext    = {bus.req_sum[SUM_W-1], bus.req_sum};
    assign sum_abs    = sum_ext[SUM_W] ? -sum_ext : sum_ext;
    assign train      = (bus.req_dir != bus.req_pred) | (sum_abs <= (SUM_W+1)'(THETA));
    assign accept     = bus.req_valid & (state == ST_IDLE);
    assign last_chunk = (chunk == CW'(NCHUNK - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && train) state_nxt = ST_RD;
            ST_RD:   state_nxt = ST_WR;
            ST_WR:   state_nxt = last_chunk ? ST_FIN : ST_RD;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            chunk    <= '0;
            addr     <= '0;
            hist_pad <= '0;
            dir_q    <= 1'b0;
            nt_q     <= 1'b0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            nt_q  <= accept & ~train;
            if (accept && train) begin
                chunk    <= '0;
                addr     <= AW'(int'(bus.req_index) * NCHUNK);
                hist_pad <= PADW'({bus.req_hist, 1'b1});
                dir_q    <= bus.req_dir;
            end else if (state == ST_WR && !last_chunk) begin
                chunk <= chunk + 1'b1;
                addr  <= addr + 1'b1;
            end
            if (state == ST_FIN) cnt <= cnt + 1'b1;
        end
    end

    // Bias occupies bit 0 of hist_pad as a constant 1; bits past NW are padding lanes.
    always_comb begin
        lane_hist = hist_pad[int'(chunk)*LANES +: LANES];
        for (int l = 0; l < LANES; l++) begin
            lane_valid[l] = (int'(chunk) * LANES + l) < NW;
        end
    end

    perceptron_train_engine_weight_vec_update #(
        .LANES    (LANES),
        .WEIGHT_W (WEIGHT_W)
    ) u_update (
        .data       (bus.wt_rd_data),
        .hist       (lane_hist),
        .lane_valid (lane_valid),
        .dir        (dir_q),
        .result     (upd)
    );

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.wt_rd_en   = (state == ST_RD);
    assign bus.wt_wr_en   = (state == ST_WR);
    assign bus.wt_rd_addr = addr;
    assign bus.wt_wr_addr = addr;
    assign bus.wt_wr_data = (state == ST_WR) ? upd : '0;
    assign bus.done       = (state == ST_FIN) | nt_q;
    assign bus.trained    = (state == ST_FIN);
    assign bus.train_cnt  = cnt;
    assign dbg_state      = state;
endmodule

// File: doc/perceptron_train_engine.md
Name: perceptron_train_engine

Overview:
- Multi-cycle training engine for the bias-inclusive perceptron predictor.
- Accepts one resolved-branch update per request and decides whether training is needed (mispredict, or |sum| <= THETA).
- When training is needed, performs chunked read-modify-write of one perceptron row (bias weight plus HIST_LEN history weights) in the external weight RAM.
- Sits between the EX-stage resolve logic and the weight table; generalises the fixed 16x3-bit combinational updater to parametrised width, history length and lane count.

Parameters:
HIST_LEN, 16, number of history weights per row
WEIGHT_W, 3, signed weight width (two's complement, saturating)
LANES, 4, weights read/written per RAM access
INDEX_W, 6, row index width
SUM_W, 9, signed perceptron output width
THETA, 4, training threshold on |sum|

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  update request valid
req_ready  out  1  engine can accept a request
req_index  in  INDEX_W  row to train
req_hist  in  HIST_LEN  history bits at prediction time (1 = taken); bit i pairs with weight i+1
req_dir  in  1  resolved direction (1 = taken)
req_pred  in  1  predicted direction
req_sum  in  SUM_W  signed perceptron output at prediction
wt_rd_en  out  1  weight RAM read strobe
wt_rd_addr  out  INDEX_W+CW  read address (CW = clog2(NCHUNK))
wt_rd_data  in  LANES*WEIGHT_W  read data, valid exactly 1 cycle after wt_rd_en
wt_wr_en  out  1  weight RAM write strobe
wt_wr_addr  out  INDEX_W+CW  write address
wt_wr_data  out  LANES*WEIGHT_W  write data
done  out  1  one-cycle pulse, request finished
trained  out  1  qualifies done: 1 = row was updated
train_cnt  out  16  count of trained requests, wraps at 2^16

Behaviour:
- Reset: state IDLE; req_ready=1; all other outputs 0; train_cnt=0. Asynchronous reset mid-operation aborts immediately; a partially written row is left as is.
- Geometry: NW = HIST_LEN+1 weights per row. Weight 0 is the bias, with an implicit history bit of 1. NCHUNK = ceil(NW/LANES). Address = index*NCHUNK + chunk. Lane l of chunk c holds weight c*LANES+l.
- Train decision, evaluated on acceptance (req_valid & req_ready):
  - train = (req_dir != req_pred) | (|req_sum| <= THETA).
  - |sum| is computed in SUM_W+1 bits, so -2^(SUM_W-1) does not overflow.
- Per weight: if dir == hist bit, saturating increment (clamp at 2^(WEIGHT_W-1)-1); else saturating decrement (clamp at -2^(WEIGHT_W-1)).
- Padding lanes (index >= NW) in the last chunk are written back unchanged.
- FSM:
  - IDLE: req_ready=1. On accept with train=0: next cycle done=1, trained=0, stay IDLE. On accept with train=1: latch inputs, chunk=0, go RD.
  - RD: wt_rd_en=1, wt_rd_addr=row base+chunk; go WR.
  - WR: wt_wr_en=1, wt_wr_data=update(wt_rd_data), same address. If chunk==NCHUNK-1, go FIN; else chunk+1, go RD.
  - FIN: done=1, trained=1, train_cnt+1; go IDLE with req_ready=1 in the same cycle FIN is left.
- req_ready=0 in RD/WR/FIN. Requests presented while not ready must be held by the source.
- Latency from accept at cycle T:
  - no-train: done at T+1.
  - train: writes at T+2, T+4, …, T+2*NCHUNK; done at T+2*NCHUNK+1.
- A read never overlaps a write, so there is no RAW hazard inside a row. Back-to-back requests to the same row are safe because each row is completed before the next accept.
- Read and write address ports are registered outputs; strobes are decoded from the registered state.

Decomposition:
- perceptron_pkg:
  - NCHUNK/CW derivation functions.
  - sat_inc / sat_dec functions parameterised by WEIGHT_W.
  - WMAX/WMIN constants.
  - FSM state enum (IDLE, RD, WR, FIN).
- Sub-module weight_vec_update: purely combinational LANES-wide update. Inputs: data, per-lane history bits, lane-valid mask, dir. Output: the updated vector. This generalises the old fixed-width updater.

Test Plan:
1. Defaults; req_index=2, dir=1, pred=0, hist=16'hFFFF, row all 0 → writes to addr 10..14 at T+2..T+10; weights 0..16 become 1; padding lanes 17..19 unchanged; done&trained at T+11; train_cnt=1.
2. dir=pred=1, sum=+5 → done at T+1, trained=0; no RAM strobes; train_cnt unchanged. Repeat with sum=+4 and sum=-4 → training runs.
3. Saturation: row weights all 3, dir=1, hist=all 1 → all remain 3. Row all -4, dir=0, hist=all 1 (bias implicit 1) → all remain -4.
4. Mixed hist=16'hA5A5, dir=0, row all 0 → weight 0 = -1; weight i+1 = -1 where hist[i]=1 and +1 where hist[i]=0.
5. req_sum=-256 (SUM_W=9), pred=dir → |sum|=256 > 4, no training, no overflow.
6. Assert rst_n low in the cycle after the second WR → outputs zero asynchronously, req_ready=1 after release, no done pulse; a fresh request completes normally.
